// File: rtl/pe_result_collector_pkg.sv
// Shared definitions for the PE result return path: array geometry, payload width,
// collector state encoding and the round-robin pointer helper.
package pe_result_collector_pkg;

  localparam int PE_ROWS         = 4;
  localparam int PE_COLS         = 4;
  localparam int COLL_NUM_PE     = PE_ROWS * PE_COLS;
  localparam int COLL_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } coll_state_e;

  // Pointer moves just past the granted channel, wrapping for any channel count.
  function automatic int unsigned rr_wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/pe_result_collector_rr_arbiter.sv
// Round-robin arbiter: first requester at/after the pointer wins. Pure combinational,
// shared with the dispatch side.
module pe_result_collector_rr_arbiter #(
  parameter int N  = 16,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  always_comb begin
    int j;
    j       = 0;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(i_ptr) + k;
      if (j >= N) j = j - N;
      if (!o_any && i_req[j]) begin
        o_any      = 1'b1;
        o_grant[j] = 1'b1;
        o_idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/pe_result_collector.sv
// Gathers per-PE results into one {pe_id,data} stream through a small FIFO and
// signals done once the expected number of results has been accepted and drained.
module pe_result_collector
  import pe_result_collector_pkg::*;
#(
  parameter int NUM_PE     = COLL_NUM_PE,
  parameter int DATA_WIDTH = COLL_DATA_WIDTH,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16,
  localparam int PW        = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [CNT_WIDTH-1:0]         expected_count,
  input  logic [NUM_PE*DATA_WIDTH-1:0] pe_result_data,
  input  logic [NUM_PE-1:0]            pe_result_valid,
  output logic [NUM_PE-1:0]            pe_result_ready,
  output logic [DATA_WIDTH-1:0]        result_data,
  output logic [PW-1:0]                result_pe_id,
  output logic                         result_valid,
  input  logic                         result_ready,
  output logic                         busy,
  output logic                         done,
  output logic [CNT_WIDTH-1:0]         collected_count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  coll_state_e          r_state, w_nxt;
  logic [PW-1:0]        r_ptr;
  logic [CNT_WIDTH-1:0] r_expected, r_count, w_cnt_inc;
  logic [AW:0]          r_wr, r_rd;
  logic [DATA_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
  logic [PW-1:0]         r_mem_id   [FIFO_DEPTH];

  logic              w_full, w_empty, w_arb_en, w_accept, w_pop, w_start;
  logic [NUM_PE-1:0] w_req, w_gnt;
  logic [PW-1:0]     w_gnt_idx;

  // Extra wrap bit distinguishes full from empty when the index bits match.
  assign w_empty   = (r_wr == r_rd);
  assign w_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_cnt_inc = r_count + CNT_WIDTH'(1);
  assign w_start   = (r_state == ST_IDLE) && start;
  assign w_arb_en  = (r_state == ST_COLLECT) && !w_full && (r_count < r_expected);
  assign w_req     = pe_result_valid & {NUM_PE{w_arb_en}};
  assign w_pop     = !w_empty && result_ready;

  pe_result_collector_rr_arbiter #(.N(NUM_PE), .IW(PW)) u_arb (
    .i_req   (w_req),
    .i_ptr   (r_ptr),
    .o_grant (w_gnt),
    .o_idx   (w_gnt_idx),
    .o_any   (w_accept)
  );

  assign pe_result_ready = w_gnt;

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (start) w_nxt = (expected_count == '0) ? ST_DONE : ST_COLLECT;
      ST_COLLECT: if (w_accept && (w_cnt_inc == r_expected)) w_nxt = ST_DRAIN;
      ST_DRAIN:   if (w_empty) w_nxt = ST_DONE;
      ST_DONE:    w_nxt = ST_IDLE;
      default:    w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_expected <= '0;
      r_count    <= '0;
      r_wr       <= '0;
      r_rd       <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_start) begin
        r_expected <= expected_count;
        r_count    <= '0;
      end else if (w_accept) begin
        r_count <= w_cnt_inc;
      end
      if (w_accept) begin
        r_ptr <= PW'(rr_wrap_inc(32'(w_gnt_idx), NUM_PE));
        r_wr  <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
    end
  end

  // Payload storage needs no reset; occupancy is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem_data[r_wr[AW-1:0]] <= pe_result_data[w_gnt_idx*DATA_WIDTH +: DATA_WIDTH];
      r_mem_id[r_wr[AW-1:0]]   <= w_gnt_idx;
    end
  end

  assign result_data     = r_mem_data[r_rd[AW-1:0]];
  assign result_pe_id    = r_mem_id[r_rd[AW-1:0]];
  assign result_valid    = !w_empty;
  assign busy            = (r_state != ST_IDLE);
  assign done            = (r_state == ST_DONE);
  assign collected_count = r_count;

endmodule
